video_pll_reset_sequencer: RTL and testbench

VIDEO_PLL_RESET_SEQUENCER -- requirements
Module: video_pll_reset_sequencer

---
 rtl/video_pll_reset_sequencer.sv | 179 +++++++++++++++++
 tb/tb_video_pll_reset_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pll_reset_sequencer.sv
// Video PLL reset sequencer. It pulses the PLL reset, waits for a stable synchronized lock,
// releases the output-clock domain resets in order, and re-sequences on lock loss or on request.
module video_pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RELEASE_GAP        = 8,
  parameter int unsigned LOCK_TIMEOUT       = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic [2:0] vid_rst_n,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] lock_lost_cnt
);

  localparam int unsigned PW = $clog2(RST_PULSE_CYCLES) + 1;
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int unsigned GW = $clog2(RELEASE_GAP) + 1;
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(RELEASE_GAP - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic          lock_meta, locked_s;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] timeout_q, timeout_d;

  logic       pll_rst_d;
  logic [2:0] vid_d;
  logic       ready_d;
  logic       terr_d;
  logic [7:0] lost_d;
  logic       enter_rst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RST_PLL;
      pulse_q       <= '0;
      stable_q      <= '0;
      gap_q         <= '0;
      timeout_q     <= '0;
      pll_rst       <= 1'b1;
      vid_rst_n     <= '0;
      ready         <= 1'b0;
      timeout_err   <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      state_q       <= state_d;
      pulse_q       <= pulse_d;
      stable_q      <= stable_d;
      gap_q         <= gap_d;
      timeout_q     <= timeout_d;
      pll_rst       <= pll_rst_d;
      vid_rst_n     <= vid_d;
      ready         <= ready_d;
      timeout_err   <= terr_d;
      lock_lost_cnt <= lost_d;
    end
  end

  // Outputs are computed from the next state so that the registered values track state_q.
  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    stable_d  = stable_q;
    gap_d     = gap_q;
    timeout_d = timeout_q;
    pll_rst_d = pll_rst;
    vid_d     = vid_rst_n;
    ready_d   = 1'b0;
    terr_d    = timeout_err;
    lost_d    = lock_lost_cnt;
    enter_rst = 1'b0;

    case (state_q)
      RST_PLL: begin
        if (pulse_q == PULSE_LAST) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
          timeout_d = '0;
        end else begin
          pulse_d = pulse_q + PW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d  = STABLE;
          stable_d = '0;
        end else if (timeout_q == TIMEOUT_LAST) begin
          terr_d    = 1'b1;
          enter_rst = 1'b1;
        end else begin
          timeout_d = timeout_q + TW'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d   = WAIT_LOCK;
          timeout_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          state_d = RELEASE;
          vid_d   = 3'b001;
          gap_d   = '0;
        end else begin
          stable_d = stable_q + SW'(1);
        end
      end
      RELEASE: begin
        // The registered vid_rst_n pattern doubles as the release phase.
        if (!locked_s) begin
          enter_rst = 1'b1;
        end else if (vid_rst_n[2]) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          vid_d = {vid_rst_n[1:0], 1'b1};
          gap_d = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          if (lock_lost_cnt != 8'hFF) begin
            lost_d = lock_lost_cnt + 8'd1;
          end
          enter_rst = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: enter_rst = 1'b1;
    endcase

    if (relock_req && (state_q != RST_PLL)) begin
      enter_rst = 1'b1;
    end

    if (enter_rst) begin
      state_d   = RST_PLL;
      pulse_d   = '0;
      stable_d  = '0;
      gap_d     = '0;
      timeout_d = '0;
      pll_rst_d = 1'b1;
      vid_d     = '0;
      ready_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_video_pll_reset_sequencer.sv
// Directed bench for video_pll_reset_sequencer: table-driven power-up/timeout timelines plus
// hand-written relock, glitch, lock-loss and asynchronous-reset sequences.
module tb_video_pll_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic [2:0] vid_rst_n;
  logic       ready;
  logic       timeout_err;
  logic [7:0] lock_lost_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  video_pll_reset_sequencer #(
    .RST_PULSE_CYCLES  (16),
    .LOCK_STABLE_CYCLES(32),
    .RELEASE_GAP       (8),
    .LOCK_TIMEOUT      (100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .vid_rst_n    (vid_rst_n),
    .ready        (ready),
    .timeout_err  (timeout_err),
    .lock_lost_cnt(lock_lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       restart;
    int         edge_n;
    logic       locked_in;
    logic       exp_pll_rst;
    logic [2:0] exp_vid;
    logic       exp_ready;
    logic       exp_terr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  task automatic goto_edge(input int n);
    while (cur < n) step(1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cur = 0;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(name, ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [0:18];
    int   n;
    int   exp_cnt;

    // Power-up: lock rises after edge 50, so locked_s is seen at edge 53, release begins at 85.
    vecs[0]  = '{1'b1,   1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0,  15, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0,  16, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0,  50, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0,  84, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0,  85, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[6]  = '{1'b0,  92, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[7]  = '{1'b0,  93, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 100, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 101, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 102, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0};
    // Lock never arrives: 16-cycle pulse + 100-cycle timeout gives a 116-cycle retry period.
    vecs[11] = '{1'b1,   1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[12] = '{1'b0,  16, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 115, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 116, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 131, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 132, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 231, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 232, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};

    reset_n    = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;

    // Asynchronous reset values before any clock edge.
    #1 reset_n = 1'b0;
    #2;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_vid", vid_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_cnt", lock_lost_cnt, 0);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].restart) begin
        pll_locked = vecs[i].locked_in;
        do_reset();
      end
      goto_edge(vecs[i].edge_n);
      check($sformatf("vec%0d_pll_rst", i), pll_rst, vecs[i].exp_pll_rst);
      check($sformatf("vec%0d_vid", i), vid_rst_n, vecs[i].exp_vid);
      check($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_terr", i), timeout_err, vecs[i].exp_terr);
      check($sformatf("vec%0d_cnt", i), lock_lost_cnt, 0);
      pll_locked = vecs[i].locked_in;
    end

    // Fresh power-up with lock present, run to RUN.
    pll_locked = 1'b1;
    do_reset();
    check("reset_clears_terr", timeout_err, 0);
    wait_ready(300, "powerup_ready");

    // relock_req from RUN, then a relock ignored in RST_PLL, then a lock glitch in STABLE.
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    cur = 0;
    check("relock_pll_rst", pll_rst, 1);
    check("relock_vid", vid_rst_n, 0);
    check("relock_ready", ready, 0);
    goto_edge(5);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    goto_edge(15);
    check("relock_ign_pulse15", pll_rst, 1);
    goto_edge(16);
    check("relock_ign_pulse16", pll_rst, 0);
    goto_edge(37);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    goto_edge(40);
    check("glitch_pll_rst40", pll_rst, 0);
    goto_edge(41);
    check("glitch_pll_rst41", pll_rst, 0);
    goto_edge(50);
    check("glitch_no_early_release", vid_rst_n, 3'b000);
    goto_edge(72);
    check("glitch_vid72", vid_rst_n, 3'b000);
    goto_edge(73);
    check("glitch_vid73", vid_rst_n, 3'b001);
    goto_edge(81);
    check("glitch_vid81", vid_rst_n, 3'b011);
    goto_edge(89);
    check("glitch_vid89", vid_rst_n, 3'b111);
    check("glitch_ready89", ready, 0);
    goto_edge(90);
    check("glitch_ready90", ready, 1);
    check("glitch_cnt", lock_lost_cnt, 0);

    // relock_req coincides with the synchronized lock fall in RUN.
    cur = 0;
    pll_locked = 1'b0;
    goto_edge(2);
    relock_req = 1'b1;
    pll_locked = 1'b1;
    goto_edge(3);
    relock_req = 1'b0;
    check("combo_pll_rst3", pll_rst, 1);
    check("combo_vid3", vid_rst_n, 0);
    check("combo_ready3", ready, 0);
    check("combo_cnt3", lock_lost_cnt, 1);
    goto_edge(18);
    check("combo_pll_rst18", pll_rst, 1);
    goto_edge(19);
    check("combo_pll_rst19", pll_rst, 0);
    check("combo_cnt19", lock_lost_cnt, 1);
    wait_ready(300, "combo_ready");

    // 300 lock losses in RUN: resets within 3 edges, counter saturates.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      step(3);
      exp_cnt = (i + 2 > 255) ? 255 : i + 2;
      check("drop_vid", vid_rst_n, 0);
      check("drop_ready", ready, 0);
      check("drop_cnt", lock_lost_cnt, exp_cnt);
      pll_locked = 1'b1;
      wait_ready(300, "drop_ready_again");
    end
    check("drop_cnt_final", lock_lost_cnt, 255);

    // Asynchronous reset while vid_rst_n = 011 during RELEASE.
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    n = 0;
    while (vid_rst_n !== 3'b011 && n < 200) begin
      step(1);
      n++;
    end
    check("release_reach_011", vid_rst_n, 3'b011);
    #3 reset_n = 1'b0;
    #1;
    check("async_pll_rst", pll_rst, 1);
    check("async_vid", vid_rst_n, 0);
    check("async_ready", ready, 0);
    check("async_terr", timeout_err, 0);
    check("async_cnt", lock_lost_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
